histogram_readout_ctrl: RTL and testbench
=========================================

# histogram_readout_ctrl

Single-clock sequencer for the histogram pipeline. Each frame it clears the 1024-bin histogram at frame start, then waits for accumulation to end. It then walks every bin address, reads each 24-bit count and hands it to the serial transmitter over a valid/ready handshake. After the last bin it sends a 24-bit checksum word. It replaces the multi-edge-triggered bin sequencing in the pipeline with one fully synchronous FSM in the `clk` domain.

## Interface
Parameters:
- NUM_BINS, 1024, number of histogram bins read per frame
- BIN_W, 10, bin address width (2^BIN_W >= NUM_BINS)
- DATA_W, 24, histogram count / transmit word width
- RD_LAT, 1, histogram read latency in clk cycles (1..4)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- frame_valid  in  1  sensor frame strobe, already synchronous to clk
- histo_done  in  1  histogram reports accumulation finished (level)
- histo_rst  out  1  one-cycle clear pulse to histogram
- bin  out  BIN_W  histogram read address
- rd_en  out  1  one-cycle read strobe for `bin`
- rd_data  in  DATA_W  count for `bin`, valid RD_LAT cycles after rd_en
- tx_data  out  DATA_W  word to serializer
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  serializer accepts word when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: a frame started while not IDLE
- frame_count  out  16  completed readouts, wraps 0xFFFF->0

## Operation
- Edge detection: `fv_d` is the previous-cycle sample of frame_valid. Rise = frame_valid & ~fv_d. Fall = ~frame_valid & fv_d. `fv_d` resets to 1, so a frame already in progress at reset release is not taken as a start.
- States and transitions:
  - IDLE: Rise goes to ARM.
  - ARM: histo_rst=1 for exactly this one cycle; next state is ACCUM.
  - ACCUM: Fall goes to WAIT_DONE.
  - WAIT_DONE: histo_done=1 goes to READ. bin=0 and checksum=0 are set on entry.
  - READ: rd_en=1 on the first cycle only. Wait RD_LAT cycles. On the cycle rd_data is valid, latch tx_data<=rd_data, set tx_valid=1, and go to SEND.
  - SEND: on handshake, tx_valid=0 and checksum<=checksum+tx_data (mod 2^DATA_W). If bin==NUM_BINS-1, go to CKSUM with tx_data<=updated checksum and tx_valid=1. Otherwise bin<=bin+1 and go to READ.
  - CKSUM: on handshake, tx_valid=0, frame_count<=frame_count+1, go to IDLE.
- tx_data and tx_valid must not change while tx_valid=1 and tx_ready=0.
- A Rise in any state other than IDLE sets overrun=1 and does not change state. The frame is not cleared or read. overrun clears only on reset.
- histo_done is ignored outside WAIT_DONE.
- A Rise and a histo_done in the same cycle in WAIT_DONE: take the READ transition and set overrun.
- bin stays at its last value in IDLE. It never wraps within a frame.

## Timing
- Reset values: state IDLE, histo_rst 0, bin 0, rd_en 0, tx_data 0, tx_valid 0, busy 0, overrun 0, frame_count 0, checksum 0.
- Reset asserted mid-operation (including SEND with tx_valid=1) forces reset values on the next edge. The in-flight word is dropped.
- Rise sampled at edge N: state=ARM and histo_rst=1 during cycle N+1, ACCUM from N+2.
- histo_done sampled at edge M in WAIT_DONE: rd_en=1 with bin=0 during cycle M+1.
- Per-bin minimum: 1 + RD_LAT + 1 cycles with tx_ready held high, i.e. 3 cycles at RD_LAT=1.
- Full readout minimum: NUM_BINS*(RD_LAT+2)+1 cycles from READ entry to IDLE.
- All outputs are registered. No combinational path from tx_ready to tx_valid.

## Test plan
- Basic frame, rd_data=bin index, tx_ready=1:
  - 1024 words 0..1023 in order, then checksum 0x07FE00.
  - frame_count=1, busy low afterwards, histo_rst exactly one pulse.
- All bins 0xFFFFFF: checksum word is 0xFFFC00 (mod-2^24 wrap).
- Backpressure, tx_ready toggling pseudo-randomly:
  - tx_data stable while stalled.
  - No duplicated or skipped bins.
  - Checksum identical to the no-stall run.
- frame_valid rises again during READ:
  - overrun=1 and stays high.
  - Current readout completes unchanged.
  - No histo_rst during readout.
- Reset pulsed while in SEND at bin 500:
  - Next cycle tx_valid=0, bin=0, state IDLE.
  - frame_valid still high at release does not start a frame.
  - The next genuine Rise runs a full readout.
- RD_LAT=3 build: rd_data sampled exactly 3 cycles after rd_en. Bin spacing is 5 cycles with tx_ready=1.

Source files
------------

// File: rtl/histogram_readout_ctrl.sv
// histogram_readout_ctrl: per-frame histogram clear, bin-by-bin readout over valid/ready,
// and a trailing mod-2^DATA_W checksum word.
module histogram_readout_ctrl #(
    parameter int NUM_BINS = 1024,
    parameter int BIN_W    = 10,
    parameter int DATA_W   = 24,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_valid,
    input  logic              histo_done,
    output logic              histo_rst,
    output logic [BIN_W-1:0]  bin,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       frame_count
);
    typedef enum logic [2:0] {IDLE, ARM, ACCUM, WAIT_DONE, READ, SEND, CKSUM} state_t;

    state_t state_q, state_d;
    logic fv_q, rise, fall, hs;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DATA_W-1:0] cksum_q, cksum_d, tx_data_q, tx_data_d;
    logic tx_valid_q, tx_valid_d, overrun_q, overrun_d;
    logic [15:0] fc_q, fc_d;
    logic [2:0] lat_q, lat_d;
    logic histo_rst_q, rd_en_q, busy_q;

    always_comb begin
        rise       = frame_valid & ~fv_q;
        fall       = ~frame_valid & fv_q;
        hs         = tx_valid_q & tx_ready;
        state_d    = state_q;
        bin_d      = bin_q;
        cksum_d    = cksum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        fc_d       = fc_q;
        lat_d      = (state_q == READ) ? lat_q + 3'd1 : 3'd0;
        overrun_d  = overrun_q | (rise & (state_q != IDLE));
        case (state_q)
            IDLE:      if (rise) state_d = ARM;
            ARM:       state_d = ACCUM;
            ACCUM:     if (fall) begin
                state_d = WAIT_DONE;
                bin_d   = '0;
                cksum_d = '0;
            end
            WAIT_DONE: if (histo_done) state_d = READ;
            // lat_q counts cycles since the read strobe; rd_data is valid when it reaches RD_LAT
            READ:      if (lat_q == 3'(RD_LAT)) begin
                tx_data_d  = rd_data;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND:      if (hs) begin
                cksum_d = cksum_q + tx_data_q;
                if (bin_q == BIN_W'(NUM_BINS - 1)) begin
                    tx_data_d = cksum_d;
                    state_d   = CKSUM;
                end else begin
                    tx_valid_d = 1'b0;
                    bin_d      = bin_q + 1'b1;
                    state_d    = READ;
                end
            end
            CKSUM:     if (hs) begin
                tx_valid_d = 1'b0;
                fc_d       = fc_q + 16'd1;
                state_d    = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fv_q        <= 1'b1;
            bin_q       <= '0;
            cksum_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            fc_q        <= '0;
            lat_q       <= '0;
            histo_rst_q <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fv_q        <= frame_valid;
            bin_q       <= bin_d;
            cksum_q     <= cksum_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            overrun_q   <= overrun_d;
            fc_q        <= fc_d;
            lat_q       <= lat_d;
            histo_rst_q <= state_d == ARM;
            rd_en_q     <= (state_d == READ) && (state_q != READ);
            busy_q      <= state_d != IDLE;
        end
    end

    assign histo_rst   = histo_rst_q;
    assign bin         = bin_q;
    assign rd_en       = rd_en_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = fc_q;
endmodule

// File: tb/tb_histogram_readout_ctrl.sv
// tb_histogram_readout_ctrl: randomized frames against a queue-based scoreboard; a
// latency-accurate histogram memory model returns junk outside the valid read cycle.
module tb_histogram_readout_ctrl;
    localparam int N = 1024, BW = 10, DW = 24, LAT = 3;

    logic clk = 1'b0, reset = 1'b1, frame_valid = 1'b0, histo_done = 1'b0, tx_ready = 1'b0;
    logic histo_rst, rd_en, tx_valid, busy, overrun;
    logic [BW-1:0] bin;
    logic [DW-1:0] rd_data, tx_data;
    logic [15:0] frame_count;

    histogram_readout_ctrl #(.NUM_BINS(N), .BIN_W(BW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .histo_done(histo_done),
        .histo_rst(histo_rst), .bin(bin), .rd_en(rd_en), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int rdy_mode = 0, rst_pulses = 0, exp_bin = 0, last_rd = -1;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] expq [$];
    logic [DW-1:0] pd [LAT];
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0] junk = '0;
    logic stall_q = 1'b0;
    logic [DW-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // memory answers exactly LAT cycles after the strobe, random noise otherwise
    always @(posedge clk) begin
        pv[0] <= rd_en;
        pd[0] <= mem[bin];
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
        junk <= DW'($urandom);
    end
    assign rd_data = pv[LAT-1] ? pd[LAT-1] : junk;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) :
                   rdy_mode == 2 ? (bin < 10'd500) : 1'b0;
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (stall_q) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, held);
            end
            if (histo_rst) rst_pulses++;
            if (rd_en) begin
                check("rd_bin", bin, exp_bin);
                exp_bin++;
                if (rdy_mode == 0 && last_rd >= 0) check("rd_spacing", cyc - last_rd, LAT + 2);
                last_rd = cyc;
            end
            if (tx_valid && tx_ready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_word: got %0h expected none", tx_data);
                end else check("tx_word", tx_data, expq.pop_front());
            end
        end
        stall_q = !reset && tx_valid && !tx_ready;
        held = tx_data;
    end

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(int kind);
        logic [DW-1:0] sum;
        sum = '0;
        expq.delete();
        for (int i = 0; i < N; i++) begin
            mem[i] = kind == 0 ? DW'(i) : kind == 1 ? {DW{1'b1}} : DW'($urandom);
            expq.push_back(mem[i]);
            sum = sum + mem[i];
        end
        expq.push_back(sum);
        exp_bin = 0;
        last_rd = -1;
        rst_pulses = 0;
        @(posedge clk);
        #1 frame_valid = 1'b1;
        @(negedge clk);
        check("arm_early", histo_rst, 0);
        @(negedge clk);
        check("arm_pulse", histo_rst, 1);
        check("busy_arm", busy, 1);
        wait_cycles(3);
        histo_done = 1'b1;
        wait_cycles(3);
        check("no_read_in_accum", exp_bin, 0);
        frame_valid = 1'b0;
    endtask

    task automatic finish_frame(int exp_fc);
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: busy still %0b after %0d cycles", busy, n);
        end
        histo_done = 1'b0;
        @(negedge clk);
        check("queue_drained", expq.size(), 0);
        check("frame_count", frame_count, exp_fc);
        check("busy_idle", busy, 0);
        check("histo_rst_pulses", rst_pulses, 1);
        check("bin_last", bin, N - 1);
        check("bins_read", exp_bin, N);
        expq.delete();
    endtask

    initial begin
        int n;
        frame_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_bin", bin, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_histo_rst", histo_rst, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_count", frame_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_cycles(10);
        check("no_start_high_at_release", busy, 0);
        check("no_clear_at_release", rst_pulses, 0);
        frame_valid = 1'b0;
        wait_cycles(2);

        rdy_mode = 0; start_frame(0); finish_frame(1);
        start_frame(1); finish_frame(2);
        rdy_mode = 1; start_frame(0); finish_frame(3);
        check("no_false_overrun", overrun, 0);

        rdy_mode = 0; start_frame(2);
        wait_cycles(200);
        frame_valid = 1'b1;
        wait_cycles(5);
        frame_valid = 1'b0;
        check("overrun_set", overrun, 1);
        finish_frame(4);
        check("overrun_sticky", overrun, 1);

        rdy_mode = 2; start_frame(0);
        n = 0;
        while (!(tx_valid && bin == 10'd500) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reached_send_500", n < 20000, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        frame_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_bin", bin, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_frame_count", frame_count, 0);
        rdy_mode = 0;
        expq.delete();
        rst_pulses = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_cycles(10);
        check("mid_rst_no_start", busy, 0);
        check("mid_rst_no_clear", rst_pulses, 0);
        frame_valid = 1'b0;
        wait_cycles(2);
        rdy_mode = 1; start_frame(2); finish_frame(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule
